// File: rtl/andor_accum_unit.sv
// andor_accum_unit: registered AND/OR lane unit with valid/ready streaming
// and a burst-accumulate mode (X = AND over beats, Y = OR over beats).
module andor_accum_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   input  logic             in_last,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic [WIDTH-1:0] out_y,
   output logic [CNT_W-1:0] out_beats
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] acc_x;
   logic [WIDTH-1:0] acc_y;
   logic [CNT_W-1:0] acc_n;
   logic             burst_mode;

   logic             eff_mode;
   logic             producing;
   logic             accept;
   logic             load_out;
   logic             out_fire;
   logic [WIDTH-1:0] res_x;
   logic [WIDTH-1:0] res_y;
   logic [CNT_W-1:0] res_n;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Handshake decode and next-state logic
   always_comb begin
      state_next = state;
      eff_mode   = mode;
      producing  = 1'b0;
      in_ready   = 1'b1;
      accept     = 1'b0;
      load_out   = 1'b0;
      out_fire   = out_valid & out_ready;

      // An open burst keeps the mode latched on its first beat
      if (state == ACCUM) eff_mode = burst_mode;
      producing = !eff_mode | in_last;
      in_ready  = producing ? (!out_valid | out_ready) : 1'b1;
      accept    = in_valid & in_ready;
      load_out  = accept & producing;

      case (state)
         IDLE:    if (accept && !producing) state_next = ACCUM;
         ACCUM:   if (accept && in_last)    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Fold the current beat into the accumulators; idle accumulators sit at
   // identity values, so the same fold yields the single-beat result.
   always_comb begin
      res_x = acc_x & (in_a & in_b);
      res_y = acc_y | (in_b | in_c);
      res_n = (acc_n == CNT_MAX) ? acc_n : acc_n + CNT_ONE;
   end

   // Burst accumulators
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_x      <= '1;
         acc_y      <= '0;
         acc_n      <= '0;
         burst_mode <= 1'b0;
      end else if (accept) begin
         if (producing) begin
            acc_x      <= '1;
            acc_y      <= '0;
            acc_n      <= '0;
            burst_mode <= 1'b0;
         end else begin
            acc_x      <= res_x;
            acc_y      <= res_y;
            acc_n      <= res_n;
            burst_mode <= 1'b1;
         end
      end
   end

   // Output register: load on a producing beat, drop valid on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_beats <= '0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         out_x     <= res_x;
         out_y     <= res_y;
         out_beats <= res_n;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/andor_accum_unit.md
# andor_accum_unit

Parametrised, registered successor to the combinational AND/OR primitive. Computes X = A & B and Y = B | C per bit over WIDTH-bit lanes. Adds a valid/ready stream interface and an accumulate mode that reduces a multi-beat burst to one result: X is the AND over all beats, Y is the OR over all beats. It sits between a stream producer and a consumer wherever gated masks or flag unions are formed.

## Interface
Parameters:
- WIDTH, 8, lane width of A/B/C/X/Y (≥1)
- CNT_W, 8, width of beat counter / out_beats (≥1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_c  input  WIDTH  operand C
- in_last  input  1  final beat of an accumulate burst
- mode  input  1  0 = bitwise per beat, 1 = accumulate burst; sampled on the first beat of a burst
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts when out_valid & out_ready
- out_x  output  WIDTH  AND result
- out_y  output  WIDTH  OR result
- out_beats  output  CNT_W  beats contributing to result, saturating

## Operation
- State: IDLE (no burst open) and ACCUM (accumulate burst open). There is one output register stage (out_valid/out_x/out_y/out_beats).
- Accumulators: acc_x (reset all-ones), acc_y (reset zero), acc_n (reset 0), burst_mode (reset 0).
- A producing beat is a beat in bitwise mode, or any beat with in_last=1 in accumulate mode.
  - For a producing beat: in_ready = !out_valid | out_ready (combinational path from out_ready).
  - For a non-last accumulate beat: in_ready = 1.
- IDLE, beat accepted with mode=0:
  - Output loads X=a&b, Y=b|c, beats=1.
  - in_last is ignored. Stay in IDLE.
- IDLE, beat accepted with mode=1, in_last=1:
  - Output loads a&b, b|c, beats=1. Stay in IDLE.
- IDLE, beat accepted with mode=1, in_last=0:
  - acc_x=a&b, acc_y=b|c, acc_n=1, burst_mode=1. Go to ACCUM.
- ACCUM, beat accepted:
  - mode input is ignored; the burst stays in accumulate mode.
  - If in_last=0: acc_x&=a&b, acc_y|=b|c, acc_n=sat(acc_n+1).
  - If in_last=1: output loads acc_x&(a&b), acc_y|(b|c), sat(acc_n+1). Accumulators return to reset values. Go to IDLE.
- Saturation: the count clamps at 2^CNT_W−1 and never wraps.
- Output register:
  - Holds its contents while out_valid & !out_ready.
  - Clears out_valid on handshake unless a new producing beat loads in the same cycle.
- Simultaneous output handshake and producing input beat in the same cycle: the new result loads, out_valid stays 1. No bubble and no loss.
- Reset, asynchronous and at any time including mid-burst:
  - out_valid=0, out_x=0, out_y=0, out_beats=0.
  - State IDLE, accumulators at reset values.
  - A partial burst is discarded.

## Timing
- Latency: result is visible on out_* the cycle after the producing beat is accepted.
- Throughput: 1 beat/cycle sustained with out_ready held high, in both modes.
- With out_ready=0 and out_valid=1:
  - Producing beats stall (in_ready=0).
  - Non-last accumulate beats still accept.
- out_* are stable while out_valid & !out_ready.
- Outputs are registered. in_ready is combinational from out_valid, out_ready, state, mode and in_last.

## Test plan
- Reset/idle: assert rst mid-stream → out_valid=0, out_x=out_y=out_beats=0 immediately. After release, in_ready=1.
- Bitwise stream, WIDTH=8, out_ready=1:
  - Beat a=F0,b=3C,c=81, then beat a=FF,b=0F,c=00.
  - → cycle+1: X=30,Y=BD,beats=1. Next cycle: X=0F,Y=0F,beats=1. out_valid stays high.
- Accumulate burst, mode=1, three beats:
  - (FF,FF,00), (F0,FF,01), (3C,FF,80, last).
  - → single output X=30, Y=FF, beats=3. No out_valid on the first two beats.
- Backpressure: hold out_ready=0 with one result pending.
  - Bitwise beat → in_ready=0 and the pending result stays stable.
  - Raise out_ready in the same cycle the new beat is presented → both handshakes occur, the new result appears the next cycle.
- Saturation, CNT_W=2: five-beat accumulate burst → out_beats=3.
- Mid-burst mode toggle and reset:
  - Toggle mode to 0 on beat 2 of a burst → treated as accumulate, single output.
  - Assert rst after beat 2 of a new burst → no output. The next single-beat accumulate burst (0F,0F,F0, last) gives X=0F, Y=FF, beats=1.
